// File: rtl/gcbp_match_scheduler_pkg.sv
// Shared parameters, state encodings and helpers for the GCBP match scheduler.
// The address helper maps a frame region and a row to a BRAM word address.
package gcbp_match_scheduler_pkg;

  localparam int unsigned C_NUM_BRAMS     = 16;
  localparam int unsigned C_SUBIMAGE_H    = 64;
  localparam int unsigned C_ADDR_W        = 9;
  localparam int unsigned C_DATA_W        = 128;
  localparam int unsigned C_REGION_STRIDE = 128;
  localparam int unsigned C_LOC_W         = 2;
  localparam int unsigned C_SUB_W         = 4;
  localparam int unsigned C_ROW_W         = 6;
  localparam int unsigned C_STATE_W       = 3;

  localparam logic [C_STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [C_STATE_W-1:0] ST_RD_CURR = 3'd1;
  localparam logic [C_STATE_W-1:0] ST_RD_PREV = 3'd2;
  localparam logic [C_STATE_W-1:0] ST_CAPTURE = 3'd3;
  localparam logic [C_STATE_W-1:0] ST_PRESENT = 3'd4;

  typedef struct packed {
    logic [C_LOC_W-1:0] curr;
    logic [C_LOC_W-1:0] prev;
  } frame_req_t;

  function automatic logic [C_ADDR_W-1:0] region_addr(input logic [C_LOC_W-1:0] loc,
                                                      input logic [C_ROW_W-1:0] row);
    return C_ADDR_W'(loc) * C_ADDR_W'(C_REGION_STRIDE) + C_ADDR_W'(row);
  endfunction

endpackage

// File: rtl/gcbp_match_scheduler_if.sv
// Row-pair handshake between the match scheduler (master) and the block matcher (slave).
interface gcbp_match_scheduler_if;
  import gcbp_match_scheduler_pkg::*;

  logic                pair_valid;
  logic                pair_ready;
  logic [C_DATA_W-1:0] pair_curr;
  logic [C_DATA_W-1:0] pair_prev;
  logic [C_SUB_W-1:0]  pair_sub;
  logic [C_ROW_W-1:0]  pair_row;
  logic                pair_last;

  modport master (
    output pair_valid,
    input  pair_ready,
    output pair_curr,
    output pair_prev,
    output pair_sub,
    output pair_row,
    output pair_last
  );

  modport slave (
    input  pair_valid,
    output pair_ready,
    input  pair_curr,
    input  pair_prev,
    input  pair_sub,
    input  pair_row,
    input  pair_last
  );

endinterface

// File: rtl/gcbp_bram_rd_mux.sv
// Registered 16:1 read-data mux; the curr and prev words are captured on separate
// enables so the second BRAM read can land while the first word is held.
module gcbp_bram_rd_mux
  import gcbp_match_scheduler_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_cap_curr,
  input  logic                            i_cap_prev,
  input  logic [C_SUB_W-1:0]              i_sel,
  input  logic [C_NUM_BRAMS*C_DATA_W-1:0] i_rd_data,
  output logic [C_DATA_W-1:0]             o_curr,
  output logic [C_DATA_W-1:0]             o_prev
);

  logic [C_DATA_W-1:0] sel_word;
  logic [C_DATA_W-1:0] curr_q;
  logic [C_DATA_W-1:0] prev_q;

  always_comb begin
    sel_word = i_rd_data[32'(i_sel) * C_DATA_W +: C_DATA_W];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      curr_q <= '0;
      prev_q <= '0;
    end else begin
      if (i_cap_curr) curr_q <= sel_word;
      if (i_cap_prev) prev_q <= sel_word;
    end
  end

  assign o_curr = curr_q;
  assign o_prev = prev_q;

endmodule

// File: rtl/gcbp_match_scheduler.sv
// Walks all sub-images row by row after each frame write, reading current and previous
// frame words from the owning BRAM and presenting them as a pair to the matcher.
module gcbp_match_scheduler
  import gcbp_match_scheduler_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_frame_done,
  input  logic [C_LOC_W-1:0]              i_curr_frame_loc,
  input  logic [C_LOC_W-1:0]              i_prev_frame_loc,
  output logic [C_NUM_BRAMS-1:0]          o_bram_rd_en,
  output logic [C_ADDR_W-1:0]             o_bram_rd_addr,
  input  logic [C_NUM_BRAMS*C_DATA_W-1:0] i_bram_rd_data,
  gcbp_match_scheduler_if.master          pair,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_overrun
);

  logic [C_STATE_W-1:0]   state_q, state_d;
  logic [C_SUB_W-1:0]     sub_q, sub_d;
  logic [C_ROW_W-1:0]     row_q, row_d;
  frame_req_t             run_q, run_d;
  frame_req_t             pend_req_q, pend_req_d;
  logic                   pend_q, pend_d;
  logic [C_NUM_BRAMS-1:0] rd_en_q, rd_en_d;
  logic [C_ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   valid_q, valid_d;
  logic [C_SUB_W-1:0]     psub_q, psub_d;
  logic [C_ROW_W-1:0]     prow_q, prow_d;
  logic                   plast_q, plast_d;
  logic                   cap_curr, cap_prev;

  frame_req_t new_req, next_req;
  logic       have_req, is_last_row, is_last, handshake, reading;

  always_comb begin
    new_req     = '{curr: i_curr_frame_loc, prev: i_prev_frame_loc};
    // A request arriving this cycle supersedes one already waiting.
    have_req    = i_frame_done | pend_q;
    next_req    = i_frame_done ? new_req : pend_req_q;
    is_last_row = (row_q == C_ROW_W'(C_SUBIMAGE_H - 1));
    is_last     = is_last_row && (sub_q == C_SUB_W'(C_NUM_BRAMS - 1));
    handshake   = valid_q & pair.pair_ready;

    state_d    = state_q;
    sub_d      = sub_q;
    row_d      = row_q;
    run_d      = run_q;
    pend_d     = pend_q;
    pend_req_d = pend_req_q;
    done_d     = 1'b0;
    overrun_d  = 1'b0;
    valid_d    = valid_q;
    psub_d     = psub_q;
    prow_d     = prow_q;
    plast_d    = plast_q;
    cap_curr   = 1'b0;
    cap_prev   = 1'b0;

    if (state_q != ST_IDLE && i_frame_done) begin
      pend_d     = 1'b1;
      pend_req_d = new_req;
      overrun_d  = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (have_req) begin
          pend_d    = 1'b0;
          overrun_d = i_frame_done & pend_q;
          run_d     = next_req;
          sub_d     = '0;
          row_d     = '0;
          if (next_req.curr == next_req.prev) done_d = 1'b1;
          else state_d = ST_RD_CURR;
        end
      end
      ST_RD_CURR: state_d = ST_RD_PREV;
      ST_RD_PREV: begin
        cap_curr = 1'b1;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cap_prev = 1'b1;
        valid_d  = 1'b1;
        psub_d   = sub_q;
        prow_d   = row_q;
        plast_d  = is_last;
        state_d  = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (handshake) begin
          valid_d = 1'b0;
          if (is_last) begin
            done_d = 1'b1;
            // An equal-location request stays pending so IDLE reports its skip.
            if (have_req && (next_req.curr != next_req.prev)) begin
              pend_d  = 1'b0;
              run_d   = next_req;
              sub_d   = '0;
              row_d   = '0;
              state_d = ST_RD_CURR;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            row_d   = row_q + 1'b1;
            if (is_last_row) sub_d = sub_q + 1'b1;
            state_d = ST_RD_CURR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    reading   = (state_d == ST_RD_CURR) || (state_d == ST_RD_PREV);
    rd_en_d   = reading ? (C_NUM_BRAMS'(1) << sub_d) : '0;
    rd_addr_d = (state_d == ST_RD_CURR) ? region_addr(run_d.curr, row_d) :
                (state_d == ST_RD_PREV) ? region_addr(run_d.prev, row_d) : '0;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      sub_q      <= '0;
      row_q      <= '0;
      run_q      <= '0;
      pend_q     <= 1'b0;
      pend_req_q <= '0;
      rd_en_q    <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      valid_q    <= 1'b0;
      psub_q     <= '0;
      prow_q     <= '0;
      plast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      row_q      <= row_d;
      run_q      <= run_d;
      pend_q     <= pend_d;
      pend_req_q <= pend_req_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      valid_q    <= valid_d;
      psub_q     <= psub_d;
      prow_q     <= prow_d;
      plast_q    <= plast_d;
    end
  end

  logic [C_DATA_W-1:0] mux_curr, mux_prev;

  gcbp_bram_rd_mux u_rd_mux (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_cap_curr (cap_curr),
    .i_cap_prev (cap_prev),
    .i_sel      (sub_q),
    .i_rd_data  (i_bram_rd_data),
    .o_curr     (mux_curr),
    .o_prev     (mux_prev)
  );

  assign o_bram_rd_en    = rd_en_q;
  assign o_bram_rd_addr  = rd_addr_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_overrun       = overrun_q;
  assign pair.pair_valid = valid_q;
  assign pair.pair_curr  = mux_curr;
  assign pair.pair_prev  = mux_prev;
  assign pair.pair_sub   = psub_q;
  assign pair.pair_row   = prow_q;
  assign pair.pair_last  = plast_q;

endmodule

// File: tb/tb_gcbp_match_scheduler.sv
// Directed bench for gcbp_match_scheduler: behavioural BRAM array, expected-pair queue,
// and timing checks for full runs, backpressure, pending/overrun, skip and mid-run reset.
module tb_gcbp_match_scheduler;
  import gcbp_match_scheduler_pkg::*;

  typedef struct packed {
    logic [127:0] curr;
    logic [127:0] prev;
    logic [3:0]   sub;
    logic [5:0]   row;
    logic         last;
  } pair_t;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_frame_done;
  logic [1:0]    i_curr_frame_loc;
  logic [1:0]    i_prev_frame_loc;
  logic [15:0]   o_bram_rd_en;
  logic [8:0]    o_bram_rd_addr;
  logic [2047:0] i_bram_rd_data;
  logic          o_busy;
  logic          o_done;
  logic          o_overrun;

  gcbp_match_scheduler_if pair_if ();

  gcbp_match_scheduler dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_frame_done     (i_frame_done),
    .i_curr_frame_loc (i_curr_frame_loc),
    .i_prev_frame_loc (i_prev_frame_loc),
    .o_bram_rd_en     (o_bram_rd_en),
    .o_bram_rd_addr   (o_bram_rd_addr),
    .i_bram_rd_data   (i_bram_rd_data),
    .pair             (pair_if),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_overrun        (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Distinct content for every (BRAM, address) so a wrong select or address shows.
  function automatic logic [127:0] bram_word(input int s, input int a);
    logic [31:0] v;
    v = {8'(s), 16'(a), 8'h5A};
    return {v, ~v, v ^ 32'h1234_5678, v};
  endfunction

  logic [127:0] rd_q [16];
  always @(posedge i_clk) begin
    for (int s = 0; s < 16; s++)
      if (o_bram_rd_en[s]) rd_q[s] <= bram_word(s, int'(o_bram_rd_addr));
  end
  for (genvar g = 0; g < 16; g++) begin : g_rd
    assign i_bram_rd_data[g*128 +: 128] = rd_q[g];
  end

  int    total = 0;
  int    bad   = 0;
  int    pop_cnt = 0;
  int    ovr_cnt = 0;
  pair_t exp_q[$];

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected pairs of a run: every sub-image in order, every row in order.
  task automatic push_run(input int c, input int p);
    pair_t e;
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 64; r++) begin
        e.curr = bram_word(s, c * 128 + r);
        e.prev = bram_word(s, p * 128 + r);
        e.sub  = 4'(s);
        e.row  = 6'(r);
        e.last = (s == 15) && (r == 63);
        exp_q.push_back(e);
      end
  endtask

  always @(negedge i_clk) begin
    pair_t act;
    if (!i_reset) begin
      if (o_overrun) ovr_cnt++;
      if (o_bram_rd_en != 16'h0) begin
        chk("rd_en_onehot", 288'($onehot(o_bram_rd_en)), 288'd1);
        chk("rd_en_while_valid", 288'(pair_if.pair_valid), 288'd0);
      end
      if (pair_if.pair_valid) begin
        act = '{curr: pair_if.pair_curr, prev: pair_if.pair_prev, sub: pair_if.pair_sub,
                row: pair_if.pair_row, last: pair_if.pair_last};
        if (exp_q.size() == 0) begin
          chk("pair_unexpected", 288'(act), 288'd0);
        end else begin
          chk("pair", 288'(act), 288'(exp_q[0]));
          if (pair_if.pair_ready) begin
            void'(exp_q.pop_front());
            pop_cnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic frame_done(input int c, input int p);
    i_curr_frame_loc = 2'(c);
    i_prev_frame_loc = 2'(p);
    i_frame_done     = 1'b1;
    tick();
    i_frame_done     = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!o_done && n < max) begin
      tick();
      n++;
    end
    chk("done_seen", 288'(o_done), 288'd1);
  endtask

  task automatic wait_pair(input int s, input int r, input int max);
    int n;
    n = 0;
    while (!(pair_if.pair_valid && pair_if.pair_sub == 4'(s) && pair_if.pair_row == 6'(r))
           && n < max) begin
      tick();
      n++;
    end
    chk("pair_reached", 288'(pair_if.pair_valid && pair_if.pair_sub == 4'(s) &&
                              pair_if.pair_row == 6'(r)), 288'd1);
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, 288'({o_bram_rd_en, pair_if.pair_valid, o_busy, o_done, o_overrun}), 288'd0);
  endtask

  initial begin
    int n;
    int base;
    i_reset          = 1'b1;
    i_frame_done     = 1'b0;
    i_curr_frame_loc = 2'd0;
    i_prev_frame_loc = 2'd0;
    pair_if.pair_ready = 1'b1;

    // Reset state and idle quiet period.
    tick();
    tick();
    chk_quiet("reset_ctrl");
    chk("reset_data", 288'({pair_if.pair_curr, pair_if.pair_prev, pair_if.pair_sub,
                            pair_if.pair_row, pair_if.pair_last, o_bram_rd_addr}), 288'd0);
    i_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("idle_quiet");
    end

    // Full run curr=1 prev=0 with ready held high.
    push_run(1, 0);
    chk("model_first", 288'({exp_q[0].sub, exp_q[0].row}), 288'd0);
    chk("model_last", 288'({exp_q[1023].sub, exp_q[1023].row, exp_q[1023].last}),
        288'({4'd15, 6'd63, 1'b1}));
    frame_done(1, 0);
    chk("t1_rd", 288'({o_bram_rd_en, o_bram_rd_addr, o_busy}), 288'({16'h0001, 9'd128, 1'b1}));
    tick();
    chk("t2_rd", 288'({o_bram_rd_en, o_bram_rd_addr}), 288'({16'h0001, 9'd0}));
    tick();
    chk("t3_idle_bus", 288'({o_bram_rd_en, pair_if.pair_valid}), 288'd0);
    tick();
    chk("t4_pair", 288'({pair_if.pair_valid, pair_if.pair_sub, pair_if.pair_row}),
        288'({1'b1, 4'd0, 6'd0}));
    chk("t4_data", 288'({pair_if.pair_curr[31:0], pair_if.pair_prev[31:0]}),
        288'({32'h0000_805A, 32'h0000_005A}));
    wait_done(5000, n);
    chk("run_cycles", 288'(n), 288'd4093);
    chk("done_busy", 288'(o_busy), 288'd0);
    chk("run_drained", 288'(exp_q.size()), 288'd0);
    tick();
    chk("done_pulse", 288'(o_done), 288'd0);

    // Backpressure, then pending requests with overrun.
    push_run(0, 3);
    frame_done(0, 3);
    wait_pair(2, 5, 2000);
    pair_if.pair_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", 288'({pair_if.pair_valid, pair_if.pair_sub, pair_if.pair_row,
                           o_bram_rd_en}), 288'({1'b1, 4'd2, 6'd5, 16'h0}));
    end
    pair_if.pair_ready = 1'b1;
    tick();
    wait_pair(2, 6, 20);
    frame_done(2, 1);
    chk("no_overrun_first", 288'(o_overrun), 288'd0);
    tick();
    tick();
    frame_done(3, 2);
    chk("overrun_pulse", 288'(o_overrun), 288'd1);
    tick();
    chk("overrun_once", 288'(o_overrun), 288'd0);
    push_run(3, 2);
    wait_done(5000, n);
    chk("pend_restart", 288'({o_busy, o_bram_rd_en, o_bram_rd_addr}),
        288'({1'b1, 16'h0001, 9'd384}));
    tick();
    wait_done(5000, n);
    chk("pend_run_end", 288'({o_busy, 32'(exp_q.size()), 32'(ovr_cnt)}),
        288'({1'b0, 32'd0, 32'd1}));
    tick();

    // Degenerate request: equal locations skip the run.
    frame_done(2, 2);
    chk("skip_done", 288'({o_done, o_busy, o_bram_rd_en}), 288'({1'b1, 1'b0, 16'h0}));
    tick();
    chk("skip_pulse", 288'(o_done), 288'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_quiet("skip_quiet");
    end

    // Reset mid-run with a request pending.
    push_run(1, 2);
    base = pop_cnt;
    frame_done(1, 2);
    n = 0;
    while (pop_cnt - base < 100 && n < 2000) begin tick(); n++; end
    frame_done(3, 0);
    while (pop_cnt - base < 300 && n < 4000) begin tick(); n++; end
    chk("pair300_reached", 288'(pop_cnt - base >= 300), 288'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk_quiet("midrst_ctrl");
    chk("midrst_data", 288'({pair_if.pair_curr, pair_if.pair_prev, pair_if.pair_sub,
                             pair_if.pair_row, pair_if.pair_last, o_bram_rd_addr}), 288'd0);
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("midrst_pend_dropped");
    end
    push_run(0, 1);
    frame_done(0, 1);
    chk("fresh_t1", 288'({o_bram_rd_en, o_bram_rd_addr}), 288'({16'h0001, 9'd0}));
    tick();
    chk("fresh_t2", 288'({o_bram_rd_en, o_bram_rd_addr}), 288'({16'h0001, 9'd128}));
    tick();
    tick();
    chk("fresh_t4", 288'({pair_if.pair_valid, pair_if.pair_sub, pair_if.pair_row}),
        288'({1'b1, 4'd0, 6'd0}));
    wait_done(5000, n);
    chk("fresh_end", 288'({o_busy, 32'(exp_q.size()), 32'(ovr_cnt)}),
        288'({1'b0, 32'd0, 32'd1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
